udp_tx_arbiter: RTL and testbench

- Frame-level round-robin arbiter that shares the single UDP transmit path (UDP header generator plus payload byte stream) between N_REQ requesters.
- Each requester presents a request with its source port, destination port and payload length, then streams its payload bytes.
- The arbiter grants one requester and pulses a header start with the latched fields. After the header generator reports done, it forwards the granted requester's payload byte stream until the frame ends.
- Sits between the application-side UDP senders and the UDP/IP TX header chain.

---
 rtl/udp_tx_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UDP TX path (header + payload) among N_REQ senders.
// Optional payload idle timeout enabled by defining UDP_TX_ARB_TIMEOUT_EN.
module udp_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_port_s,
  input  logic [16*N_REQ-1:0]  req_port_d,
  input  logic [16*N_REQ-1:0]  req_len,
  input  logic [8*N_REQ-1:0]   s_data,
  input  logic [N_REQ-1:0]     s_valid,
  input  logic [N_REQ-1:0]     s_last,
  output logic [N_REQ-1:0]     s_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 hdr_start,
  output logic [15:0]          hdr_port_s,
  output logic [15:0]          hdr_port_d,
  output logic [15:0]          hdr_len,
  input  logic                 hdr_done,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 len_err
);

  localparam int          IDXW    = $clog2(N_REQ);
  localparam logic [15:0] MAX_LEN = 16'd65527;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("udp_tx_arbiter: N_REQ or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;

  // UDP length field covers the 8-byte header plus payload.
  function automatic logic [15:0] udp_len(input logic [15:0] len);
    return len + 16'd8;
  endfunction

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   gidx_q, gidx_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [15:0]       port_s_q, port_s_d;
  logic [15:0]       port_d_q, port_d_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       hdr_len_q, hdr_len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              hdr_pend_q, hdr_pend_d;
  logic              len_err_q, len_err_d;

  logic              win_vld;
  logic [IDXW-1:0]   win_idx;
  logic [IDXW-1:0]   scan_idx;
  logic [15:0]       win_len;
  logic              g_valid;
  logic              g_last;
  logic              beat;
  logic              cnt_end;

`ifdef UDP_TX_ARB_TIMEOUT_EN
  logic [15:0]       idle_q, idle_d;
`endif

  // Rotating-priority scan starting just after the last owner.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = IDXW'((int'(ptr_q) + k) % N_REQ);
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign win_len = req_len[{win_idx, 4'b0000} +: 16];
  assign g_valid = s_valid[gidx_q];
  assign g_last  = s_last[gidx_q];
  assign cnt_end = (cnt_q == len_q - 16'd1);
  assign beat    = (state_q == PAYLOAD) && g_valid && m_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    port_s_d   = port_s_q;
    port_d_d   = port_d_q;
    len_d      = len_q;
    hdr_len_d  = hdr_len_q;
    cnt_d      = cnt_q;
    hdr_pend_d = hdr_pend_q;
    len_err_d  = 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
    idle_d     = 16'd0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          if (win_len > MAX_LEN) begin
            // Oversized request is skipped; pointer moves past it so others are not starved.
            len_err_d = 1'b1;
            ptr_d     = win_idx;
          end else begin
            grant_d    = N_REQ'(1) << win_idx;
            gidx_d     = win_idx;
            port_s_d   = req_port_s[{win_idx, 4'b0000} +: 16];
            port_d_d   = req_port_d[{win_idx, 4'b0000} +: 16];
            len_d      = win_len;
            hdr_len_d  = udp_len(win_len);
            hdr_pend_d = 1'b1;
            state_d    = HDR;
          end
        end
      end
      HDR: begin
        hdr_pend_d = 1'b0;
        if (hdr_done) begin
          cnt_d   = 16'd0;
          state_d = (len_q == 16'd0) ? DONE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (beat) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_end) begin
            len_err_d = !g_last;
            state_d   = DONE;
          end else if (g_last) begin
            len_err_d = 1'b1;
            state_d   = DONE;
          end
        end
`ifdef UDP_TX_ARB_TIMEOUT_EN
        else begin
          idle_d = idle_q + 16'd1;
          if (idle_d == 16'(TIMEOUT)) begin
            len_err_d = 1'b1;
            state_d   = DONE;
          end
        end
`endif
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = gidx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr_q      <= IDXW'(N_REQ - 1);
      gidx_q     <= '0;
      grant_q    <= '0;
      port_s_q   <= '0;
      port_d_q   <= '0;
      len_q      <= '0;
      hdr_len_q  <= '0;
      cnt_q      <= '0;
      hdr_pend_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      port_s_q   <= port_s_d;
      port_d_q   <= port_d_d;
      len_q      <= len_d;
      hdr_len_q  <= hdr_len_d;
      cnt_q      <= cnt_d;
      hdr_pend_q <= hdr_pend_d;
      len_err_q  <= len_err_d;
    end
  end

`ifdef UDP_TX_ARB_TIMEOUT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) idle_q <= 16'd0;
    else        idle_q <= idle_d;
  end
`endif

  // Payload is a combinational pass-through of the owner's stream; the counted end forces m_last.
  always_comb begin
    s_ready = '0;
    m_data  = 8'd0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    if (state_q == PAYLOAD) begin
      s_ready[gidx_q] = m_ready;
      m_data          = s_data[{gidx_q, 3'b000} +: 8];
      m_valid         = g_valid;
      m_last          = g_last | cnt_end;
    end
  end

  assign hdr_start  = (state_q == HDR) && hdr_pend_q;
  assign grant      = grant_q;
  assign hdr_port_s = port_s_q;
  assign hdr_port_d = port_d_q;
  assign hdr_len    = hdr_len_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: directed frames, monitor pops expected headers/beats.
module tb_udp_tx_arbiter;
  localparam int N = 4;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    req, s_valid, s_last, s_ready, grant;
  logic [16*N-1:0] req_port_s, req_port_d, req_len;
  logic [8*N-1:0]  s_data;
  logic            hdr_start, hdr_done, m_valid, m_last, m_ready, len_err;
  logic [15:0]     hdr_port_s, hdr_port_d, hdr_len;
  logic [7:0]      m_data;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  typedef struct packed {logic [N-1:0] g; logic [15:0] ps; logic [15:0] pd; logic [15:0] len;} hdr_t;
  typedef struct packed {logic [7:0] d; logic l;} beat_t;

  hdr_t  exp_hdr[$];
  beat_t exp_beat[$];

  int nbytes[N];
  int lastpos[N];
  int byte_idx[N];
  int hdr_delay = 0;
  bit mr_toggle = 1'b0;

  always #5 aclk = ~aclk;

  udp_tx_arbiter #(.N_REQ(N), .TIMEOUT(1024)) dut (
    .aclk(aclk), .areset(areset), .req(req),
    .req_port_s(req_port_s), .req_port_d(req_port_d), .req_len(req_len),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .grant(grant), .hdr_start(hdr_start), .hdr_port_s(hdr_port_s),
    .hdr_port_d(hdr_port_d), .hdr_len(hdr_len), .hdr_done(hdr_done),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .len_err(len_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  task automatic push_hdr(input logic [N-1:0] g, input logic [15:0] ps, input logic [15:0] pd,
                          input logic [15:0] len);
    exp_hdr.push_back(hdr_t'{g, ps, pd, len});
  endtask

  task automatic push_beat(input logic [7:0] d, input logic l);
    exp_beat.push_back(beat_t'{d, l});
  endtask

  task automatic set_req(input int i, input logic [15:0] ps, input logic [15:0] pd,
                         input logic [15:0] len, input int nb, input int lp);
    req_port_s[16*i +: 16] = ps;
    req_port_d[16*i +: 16] = pd;
    req_len[16*i +: 16]    = len;
    nbytes[i]              = nb;
    lastpos[i]             = lp;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge aclk); #1;
      n++;
    end while (!(grant == '0 && exp_hdr.size() == 0 && exp_beat.size() == 0) && n < 400);
    if (n >= 400) begin
      fail_evt({name, "_timeout"}, 64'(exp_hdr.size() + exp_beat.size()));
      exp_hdr.delete();
      exp_beat.delete();
    end
    repeat (3) @(negedge aclk);
    @(posedge aclk); #1;
  endtask

  task automatic wait_hdr_left(input int left, input string name);
    int n = 0;
    while (exp_hdr.size() > left && n < 400) begin
      @(negedge aclk); #1;
      n++;
    end
    if (exp_hdr.size() > left) fail_evt({name, "_timeout"}, 64'(exp_hdr.size()));
  endtask

  task automatic wait_beats_done(input string name);
    int n = 0;
    while (exp_beat.size() > 0 && n < 400) begin
      @(negedge aclk); #1;
      n++;
    end
    if (exp_beat.size() > 0) fail_evt({name, "_timeout"}, 64'(exp_beat.size()));
  endtask

  // Scoreboard monitor
  initial begin
    hdr_t  eh;
    beat_t eb;
    forever begin
      @(negedge aclk);
      if (hdr_start === 1'b1) begin
        if (exp_hdr.size() == 0) fail_evt("hdr_unexpected", 64'({grant, hdr_port_s, hdr_port_d, hdr_len}));
        else begin
          eh = exp_hdr.pop_front();
          check("hdr", 64'({grant, hdr_port_s, hdr_port_d, hdr_len}), 64'(eh));
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (exp_beat.size() == 0) fail_evt("beat_unexpected", 64'({m_data, m_last}));
        else begin
          eb = exp_beat.pop_front();
          check("beat", 64'({m_data, m_last}), 64'(eb));
        end
      end
      if (len_err === 1'b1) err_cnt++;
    end
  end

  // Requester payload model and TX-side m_ready
  initial begin
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b1;
    forever begin
      @(negedge aclk);
      for (int i = 0; i < N; i++)
        if (s_valid[i] && s_ready[i]) byte_idx[i]++;
      @(posedge aclk); #1;
      for (int i = 0; i < N; i++) begin
        if (!grant[i]) byte_idx[i] = 0;
        s_valid[i]         = grant[i] && (byte_idx[i] < nbytes[i]);
        s_last[i]          = grant[i] && (byte_idx[i] == lastpos[i]);
        s_data[8*i +: 8]   = 8'(16 * (i + 1) + byte_idx[i]);
      end
      m_ready = mr_toggle ? ~m_ready : 1'b1;
    end
  end

  // Header generator model
  initial begin
    hdr_done = 1'b0;
    forever begin
      @(negedge aclk);
      if (hdr_start === 1'b1) begin
        repeat (hdr_delay) @(negedge aclk);
        hdr_done = 1'b1;
        @(posedge aclk); #1;
        hdr_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    areset     = 1'b1;
    req        = '0;
    req_port_s = '0;
    req_port_d = '0;
    req_len    = '0;
    for (int i = 0; i < N; i++) begin
      nbytes[i]  = 0;
      lastpos[i] = -1;
    end
    repeat (3) @(posedge aclk); #1;
    check("rst_grant_sready", 64'({grant, s_ready}), 64'(0));
    check("rst_hdr", 64'({hdr_start, hdr_port_s, hdr_port_d, hdr_len}), 64'(0));
    check("rst_m", 64'({m_valid, m_last, m_data, len_err}), 64'(0));
    areset = 1'b0;
    @(posedge aclk); #1;

    // Basic frame, 3-cycle header latency
    set_req(0, 16'h1234, 16'h0050, 16'd4, 4, 3);
    hdr_delay = 3;
    push_hdr(4'b0001, 16'h1234, 16'h0050, 16'd12);
    push_beat(8'h10, 1'b0); push_beat(8'h11, 1'b0);
    push_beat(8'h12, 1'b0); push_beat(8'h13, 1'b1);
    err_cnt = 0;
    req[0] = 1'b1;
    @(posedge aclk); #1;
    check("grant_latency", 64'(grant), 64'(4'b0001));
    req[0] = 1'b0;
    wait_idle("basic");
    check("basic_len_err", 64'(err_cnt), 64'(0));

    // Round robin from reset pointer, all requesters held
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    hdr_delay = 0;
    set_req(0, 16'h1000, 16'h2000, 16'd1, 1, 0);
    set_req(1, 16'h1001, 16'h2001, 16'd1, 1, 0);
    set_req(2, 16'h1002, 16'h2002, 16'd1, 1, 0);
    set_req(3, 16'h1003, 16'h2003, 16'd1, 1, 0);
    for (int r = 0; r < 2; r++) begin
      push_hdr(4'b0001, 16'h1000, 16'h2000, 16'd9); push_beat(8'h10, 1'b1);
      push_hdr(4'b0010, 16'h1001, 16'h2001, 16'd9); push_beat(8'h20, 1'b1);
      push_hdr(4'b0100, 16'h1002, 16'h2002, 16'd9); push_beat(8'h30, 1'b1);
      push_hdr(4'b1000, 16'h1003, 16'h2003, 16'd9); push_beat(8'h40, 1'b1);
    end
    err_cnt = 0;
    req = 4'b1111;
    wait_hdr_left(0, "rr");
    req = 4'b0000;
    wait_idle("rr");
    check("rr_len_err", 64'(err_cnt), 64'(0));

    // Short frame: s_last on 2nd of 3 bytes, with m_ready stalls
    set_req(0, 16'h0400, 16'h0401, 16'd3, 3, 1);
    hdr_delay = 1;
    mr_toggle = 1'b1;
    push_hdr(4'b0001, 16'h0400, 16'h0401, 16'd11);
    push_beat(8'h10, 1'b0); push_beat(8'h11, 1'b1);
    err_cnt = 0;
    req[0] = 1'b1;
    @(posedge aclk); #1;
    req[0] = 1'b0;
    wait_idle("short");
    mr_toggle = 1'b0;
    check("short_len_err", 64'(err_cnt), 64'(1));

    // Long frame: no s_last, forced at counted end, 3rd byte refused
    set_req(1, 16'h0500, 16'h0501, 16'd2, 3, -1);
    hdr_delay = 2;
    push_hdr(4'b0010, 16'h0500, 16'h0501, 16'd10);
    push_beat(8'h20, 1'b0); push_beat(8'h21, 1'b1);
    err_cnt = 0;
    req[1] = 1'b1;
    @(posedge aclk); #1;
    req[1] = 1'b0;
    wait_beats_done("long");
    @(negedge aclk); #1;
    check("no_third_byte", 64'({s_valid[1], s_ready[1]}), 64'(2'b10));
    wait_idle("long");
    check("long_len_err", 64'(err_cnt), 64'(1));

    // Zero-length payload, header done in the same cycle as start
    set_req(2, 16'hABCD, 16'h0035, 16'd0, 0, -1);
    hdr_delay = 0;
    push_hdr(4'b0100, 16'hABCD, 16'h0035, 16'd8);
    err_cnt = 0;
    req[2] = 1'b1;
    @(posedge aclk); #1;
    req[2] = 1'b0;
    wait_idle("len0");
    check("len0_len_err", 64'(err_cnt), 64'(0));

    // Over-length request is skipped
    set_req(3, 16'h0900, 16'h0901, 16'd65528, 0, -1);
    err_cnt = 0;
    req[3] = 1'b1;
    @(posedge aclk); #1;
    req[3] = 1'b0;
    repeat (4) @(posedge aclk); #1;
    check("overlen_len_err", 64'(err_cnt), 64'(1));
    check("overlen_no_grant", 64'(grant), 64'(0));

    // Maximum legal length, aborted by reset mid-payload
    set_req(0, 16'h0600, 16'h0601, 16'hFFF7, 100, -1);
    hdr_delay = 1;
    push_hdr(4'b0001, 16'h0600, 16'h0601, 16'hFFFF);
    for (int k = 0; k < 5; k++) push_beat(8'(8'h10 + k), 1'b0);
    err_cnt = 0;
    req[0] = 1'b1;
    @(posedge aclk); #1;
    req[0] = 1'b0;
    wait_beats_done("maxlen");
    areset = 1'b1;
    #1;
    check("rst_mid_grant", 64'(grant), 64'(0));
    check("rst_mid_m", 64'({m_valid, s_ready}), 64'(0));
    @(posedge aclk); #1;
    areset = 1'b0;
    check("rst_mid_len_err", 64'(err_cnt), 64'(0));

    // After reset requester 0 wins first, then requester 1
    set_req(0, 16'h0700, 16'h0701, 16'd1, 1, 0);
    set_req(1, 16'h0800, 16'h0801, 16'd1, 1, 0);
    hdr_delay = 2;
    push_hdr(4'b0001, 16'h0700, 16'h0701, 16'd9); push_beat(8'h10, 1'b1);
    push_hdr(4'b0010, 16'h0800, 16'h0801, 16'd9); push_beat(8'h20, 1'b1);
    err_cnt = 0;
    req = 4'b0011;
    wait_hdr_left(1, "post_rst");
    req[0] = 1'b0;
    wait_hdr_left(0, "post_rst");
    req[1] = 1'b0;
    wait_idle("post_rst");
    check("post_rst_len_err", 64'(err_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
